hazard_control: RTL

- Stall/flush controller in the decode stage of the 5-stage pipeline.
- Consumes the per-operand bypass match vectors produced for the F/D instruction, plus the D/X instruction, branch resolution and the multdiv handshake.
- Drives the pipeline-register enables and bubble inserts.
- Handles three cases: load-use stalls, multi-cycle mul/div freezes with a timeout, and branch flushes. Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_control_pkg.sv | 27 ++
 rtl/hazard_control_md_fsm.sv | 67 ++++++
 rtl/hazard_control.sv | 100 ++++++++++
 3 files changed

// File: rtl/hazard_control_pkg.sv
// Shared decode constants, multdiv FSM state type and instruction classifiers
// for the decode-stage hazard controller.
package hazard_control_pkg;

   localparam logic [4:0]  OP_RTYPE = 5'b00000;
   localparam logic [4:0]  OP_LW    = 5'b01000;
   localparam logic [4:0]  ALU_MUL  = 5'b00110;
   localparam logic [4:0]  ALU_DIV  = 5'b00111;
   localparam logic [31:0] NOP      = 32'h0;

   typedef enum logic [1:0] {
      MD_IDLE  = 2'd0,
      MD_START = 2'd1,
      MD_BUSY  = 2'd2,
      MD_DONE  = 2'd3
   } md_state_e;

   function automatic logic is_load(input logic [31:0] insn);
      return insn[31:27] == OP_LW;
   endfunction

   function automatic logic is_muldiv(input logic [31:0] insn);
      return (insn[31:27] == OP_RTYPE) &&
             ((insn[6:2] == ALU_MUL) || (insn[6:2] == ALU_DIV));
   endfunction

endpackage

// File: rtl/hazard_control_md_fsm.sv
// Multdiv sequencing FSM: issues the start pulse, freezes the pipeline while
// the unit is busy and aborts with a sticky flag after MD_TIMEOUT busy cycles.
module md_fsm
   import hazard_control_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 40
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_req_i,
   input  logic ready_i,
   output logic freeze_o,
   output logic start_o,
   output logic timeout_o
);

   localparam int unsigned BUSY_W = $clog2(MD_TIMEOUT + 1);

   md_state_e          state_q, state_d;
   logic [BUSY_W-1:0]  busy_cnt_q, busy_cnt_d;
   logic               timeout_q, timeout_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= MD_IDLE;
         busy_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_cnt_q <= busy_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // New requests are only accepted in IDLE so a mul/div still held in D/X
   // during DONE is not restarted.
   always_comb begin
      state_d    = state_q;
      busy_cnt_d = busy_cnt_q;
      timeout_d  = timeout_q;
      case (state_q)
         MD_IDLE: begin
            if (start_req_i) begin
               state_d    = MD_START;
               busy_cnt_d = '0;
            end
         end
         MD_START: state_d = MD_BUSY;
         MD_BUSY: begin
            busy_cnt_d = busy_cnt_q + BUSY_W'(1);
            if (ready_i) begin
               state_d = MD_DONE;
            end else if (busy_cnt_q == BUSY_W'(MD_TIMEOUT - 1)) begin
               state_d   = MD_IDLE;
               timeout_d = 1'b1;
            end
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   assign freeze_o  = (state_q == MD_START) || (state_q == MD_BUSY);
   assign start_o   = (state_q == MD_START);
   assign timeout_o = timeout_q;

endmodule

// File: rtl/hazard_control.sv
// Decode-stage stall/flush controller: load-use stalls, multdiv freezes and
// branch flushes, plus a saturating stall-cycle counter.
module hazard_control
   import hazard_control_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 40,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      de_instruction,
   input  logic [2:0]       bypass_A_sig,
   input  logic [2:0]       bypass_B_sig,
   input  logic             branch_taken,
   input  logic             multdiv_ready,
   output logic             pc_enable,
   output logic             fd_enable,
   output logic             fd_flush,
   output logic             de_enable,
   output logic             de_bubble,
   output logic             em_bubble,
   output logic             multdiv_start,
   output logic             multdiv_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   logic             load_use;
   logic             md_freeze;
   logic             md_start;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             unused_bypass;

   // Only the D/X match bits matter; X/M and M/W are covered by forwarding.
   assign unused_bypass = ^{bypass_A_sig[1:0], bypass_B_sig[1:0]};

   assign load_use = is_load(de_instruction) &&
                     (bypass_A_sig[2] || bypass_B_sig[2]) &&
                     (de_instruction[26:22] != 5'd0);

   md_fsm #(
      .MD_TIMEOUT (MD_TIMEOUT)
   ) u_md_fsm (
      .clk_i       (clock),
      .rst_ni      (reset),
      .start_req_i (is_muldiv(de_instruction)),
      .ready_i     (multdiv_ready),
      .freeze_o    (md_freeze),
      .start_o     (md_start),
      .timeout_o   (multdiv_timeout)
   );

   assign multdiv_start = md_start && reset;

   // Priority: reset, multdiv freeze, branch flush, load-use stall, run.
   always_comb begin
      pc_enable = 1'b1;
      fd_enable = 1'b1;
      de_enable = 1'b1;
      fd_flush  = 1'b0;
      de_bubble = 1'b0;
      em_bubble = 1'b0;
      if (!reset) begin
         pc_enable = 1'b0;
         fd_enable = 1'b0;
         de_enable = 1'b0;
         de_bubble = 1'b1;
         em_bubble = 1'b1;
      end else if (md_freeze) begin
         pc_enable = 1'b0;
         fd_enable = 1'b0;
         de_enable = 1'b0;
         em_bubble = 1'b1;
      end else if (branch_taken) begin
         fd_flush  = 1'b1;
         de_bubble = 1'b1;
      end else if (load_use) begin
         pc_enable = 1'b0;
         fd_enable = 1'b0;
         de_bubble = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_enable && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;

endmodule
